// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU data-memory arbiter.
// Holds the arbiter state enum, the MMU region bases and the legal byte-enable codes.
package mmu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLock0,
    StLock1
  } arb_state_t;

  // MMU region base addresses
  localparam logic [31:0] ImBase = 32'h0000_0000;
  localparam logic [31:0] DmBase = 32'h1000_0000;
  localparam logic [31:0] IoBase = 32'h8000_0000;

  // Legal byte-enable codes
  localparam logic [3:0] BeWord   = 4'b1111;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeByte0  = 4'b0001;
  localparam logic [3:0] BeByte1  = 4'b0010;
  localparam logic [3:0] BeByte2  = 4'b0100;
  localparam logic [3:0] BeByte3  = 4'b1000;

  function automatic logic be_legal(input logic [3:0] be);
    return (be == BeWord) || (be == BeHalfHi) || (be == BeHalfLo) || (be == BeByte0) ||
           (be == BeByte1) || (be == BeByte2) || (be == BeByte3);
  endfunction

endpackage

// File: rtl/mmu_dm_arbiter_if.sv
// Bundle of both requester ports and the MMU data-memory port.
// slave is the arbiter's view; master is the requesters' and MMU's view.
interface mmu_dm_arbiter_if;
  logic        req0, req1;
  logic        lock0, lock1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        we0, we1;
  logic [3:0]  be0, be1;
  logic        sgn0, sgn1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] dm_addr;
  logic [31:0] dm_di;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic        is_signed;
  logic [31:0] dm_do;

  modport slave (
    input  req0, req1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  we0, we1, be0, be1, sgn0, sgn1, dm_do,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output dm_addr, dm_di, dm_we, dm_be, is_signed
  );

  modport master (
    output req0, req1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output we0, we1, be0, be1, sgn0, sgn1, dm_do,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  dm_addr, dm_di, dm_we, dm_be, is_signed
  );
endinterface

// File: rtl/mmu_arb_starve_cnt.sv
// Saturating count of consecutive cycles requester 1 was denied.
// hit flags that the count has reached MAX_WAIT.
module mmu_arb_starve_cnt #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic req,
  input  logic gnt,
  output logic hit
);

  localparam logic [WAIT_W-1:0] MaxCnt = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Clear on idle or grant, otherwise count up and hold at MAX_WAIT
  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q != MaxCnt) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == MaxCnt);

endmodule

// File: rtl/mmu_dm_arbiter.sv
// Arbitrates the MMU data-memory port between the load/store unit (0) and the
// debug/loader port (1). Fixed priority with a starvation guard for requester 1,
// optional lock to keep ownership across accesses, one-cycle read-data return.
// Define MMU_DM_ARBITER_RR_EN to make idle arbitration round-robin.
module mmu_dm_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 4
) (
  input logic            clk,
  input logic            resetb,
  mmu_dm_arbiter_if.slave bus
);
  import mmu_pkg::*;

  arb_state_t state_q, state_d;
  logic       gnt0, gnt1;
  logic       pick1;
  logic       hit;
  logic       v_p, own_p;

  mmu_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT),
    .WAIT_W  (WAIT_W)
  ) u_starve_cnt (
    .clk   (clk),
    .resetb(resetb),
    .req   (bus.req1),
    .gnt   (gnt1),
    .hit   (hit)
  );

`ifdef MMU_DM_ARBITER_RR_EN
  logic last_q;

  // Remember who owned the most recent access
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      last_q <= 1'b0;
    end else if (gnt0 || gnt1) begin
      last_q <= gnt1;
    end
  end

  assign pick1 = bus.req1 && (hit || !bus.req0 || !last_q);
`else
  assign pick1 = bus.req1 && (hit || !bus.req0);
`endif

  // Grant decode and lock state transitions
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick1) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = bus.req0;
        end
        if (gnt1 && bus.lock1) begin
          state_d = StLock1;
        end else if (gnt0 && bus.lock0) begin
          state_d = StLock0;
        end
      end
      StLock0: begin
        gnt0 = bus.req0;
        // Release on the final unlocked access or when the owner walks away
        if (!bus.req0 || !bus.lock0) state_d = StIdle;
      end
      StLock1: begin
        gnt1 = bus.req1;
        if (!bus.req1 || !bus.lock1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // No grants may leak out while reset is held
    if (!resetb) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // MMU drive mux; idle value is a side-effect-free word read of the IM region
  always_comb begin
    bus.dm_addr   = ImBase;
    bus.dm_di     = '0;
    bus.dm_we     = 1'b0;
    bus.dm_be     = BeWord;
    bus.is_signed = 1'b0;
    if (gnt1) begin
      bus.dm_addr   = bus.addr1;
      bus.dm_di     = bus.wdata1;
      bus.dm_we     = bus.we1;
      bus.dm_be     = bus.be1;
      bus.is_signed = bus.sgn1;
    end else if (gnt0) begin
      bus.dm_addr   = bus.addr0;
      bus.dm_di     = bus.wdata0;
      bus.dm_we     = bus.we0;
      bus.dm_be     = bus.be0;
      bus.is_signed = bus.sgn0;
    end
  end

  // State and response-tracking registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      v_p     <= 1'b0;
      own_p   <= 1'b0;
    end else begin
      state_q <= state_d;
      v_p     <= gnt0 | gnt1;
      own_p   <= gnt1;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = v_p && !own_p;
  assign bus.rvalid1 = v_p && own_p;
  assign bus.rdata0  = bus.rvalid0 ? bus.dm_do : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.dm_do : '0;

endmodule

// File: tb/tb_mmu_dm_arbiter.sv
// Randomised and directed bench for mmu_dm_arbiter with a queue-based scoreboard.
// Honours MMU_DM_ARBITER_RR_EN to pick the matching reference arbitration rule.
module tb_mmu_dm_arbiter;
  import mmu_pkg::*;

  localparam int MaxWait = 8;
`ifdef MMU_DM_ARBITER_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  typedef struct {
    int          cyc;
    int          owner;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  mmu_dm_arbiter_if bus();

  mmu_dm_arbiter #(
    .MAX_WAIT(MaxWait),
    .WAIT_W  (4)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .bus   (bus)
  );

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  // Reference model: lock owner (-1 none), denied-cycle count, last owner
  int    m_lock = -1;
  int    m_wait = 0;
  int    m_last = 0;
  logic  e0 = 1'b0, e1 = 1'b0;
  logic  dut_g0 = 1'b0, dut_g1 = 1'b0;
  logic [3:0]  legal_be [7];
  logic [31:0] bases [3];

  function automatic logic [31:0] mmu_resp(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // MMU model: returns a address-derived word one cycle after each access
  always @(posedge clk) bus.dm_do <= mmu_resp(bus.dm_addr);

  // Monitor: every cycle either the expected response or silence
  always @(negedge clk) begin
    resp_t r;
    #2;
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      r = exp_q.pop_front();
      check("rvalid0", bus.rvalid0, r.owner == 0);
      check("rvalid1", bus.rvalid1, r.owner == 1);
      if (r.owner == 0) begin
        check("rdata0", bus.rdata0, r.data);
        check("rdata1_quiet", bus.rdata1, 0);
      end else begin
        check("rdata1", bus.rdata1, r.data);
        check("rdata0_quiet", bus.rdata0, 0);
      end
    end else begin
      check("rvalid0_quiet", bus.rvalid0, 0);
      check("rvalid1_quiet", bus.rvalid1, 0);
      check("rdata0_quiet", bus.rdata0, 0);
      check("rdata1_quiet", bus.rdata1, 0);
    end
  end

  function automatic logic [31:0] rand_addr();
    return bases[$urandom_range(0, 2)] | ($urandom & 32'h0FFF_FFFC);
  endfunction

  task automatic set0(input logic r, input logic l, input logic w, input logic [31:0] a);
    bus.req0 = r; bus.lock0 = l; bus.we0 = w; bus.addr0 = a;
    bus.wdata0 = $urandom; bus.be0 = BeWord; bus.sgn0 = 1'($urandom_range(0, 1));
  endtask

  task automatic set1(input logic r, input logic l, input logic w, input logic [31:0] a);
    bus.req1 = r; bus.lock1 = l; bus.we1 = w; bus.addr1 = a;
    bus.wdata1 = $urandom; bus.be1 = BeWord; bus.sgn1 = 1'($urandom_range(0, 1));
  endtask

  // New random request unless the previous one is still waiting for its grant
  task automatic rand_inputs();
    if (!(bus.req0 && !e0)) begin
      set0(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), rand_addr());
      bus.be0 = legal_be[$urandom_range(0, 6)];
    end
    if (!(bus.req1 && !e1)) begin
      set1(1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), rand_addr());
      bus.be1 = legal_be[$urandom_range(0, 6)];
    end
  endtask

  // One clock: check grants/MMU drive against the model, then advance it
  task automatic cycle();
    logic r0, r1, l0, l1;
    logic [31:0] ea, ed;
    logic        ewe, esg;
    logic [3:0]  ebe;
    #1;
    r0 = bus.req0; r1 = bus.req1; l0 = bus.lock0; l1 = bus.lock1;
    e0 = 1'b0; e1 = 1'b0;
    if (m_lock == 0) e0 = r0;
    else if (m_lock == 1) e1 = r1;
    else if (r1 && (m_wait == MaxWait || !r0 || (RrEn && m_last == 0))) e1 = 1'b1;
    else e0 = r0;
    dut_g0 = bus.gnt0;
    dut_g1 = bus.gnt1;
    check("gnt0", dut_g0, e0);
    check("gnt1", dut_g1, e1);
    ea = 32'h0; ed = 32'h0; ewe = 1'b0; ebe = 4'hF; esg = 1'b0;
    if (e1) begin
      ea = bus.addr1; ed = bus.wdata1; ewe = bus.we1; ebe = bus.be1; esg = bus.sgn1;
    end else if (e0) begin
      ea = bus.addr0; ed = bus.wdata0; ewe = bus.we0; ebe = bus.be0; esg = bus.sgn0;
    end
    check("dm_addr", bus.dm_addr, ea);
    check("dm_di", bus.dm_di, ed);
    check("dm_we", bus.dm_we, ewe);
    check("dm_be", bus.dm_be, ebe);
    check("is_signed", bus.is_signed, esg);
    if (e0 || e1) exp_q.push_back('{cyc: cyc + 1, owner: (e1 ? 1 : 0), data: mmu_resp(ea)});
    @(posedge clk);
    cyc++;
    if (m_lock == -1) begin
      if (e1 && l1) m_lock = 1;
      else if (e0 && l0) m_lock = 0;
    end else if (m_lock == 0) begin
      if (!r0 || !l0) m_lock = -1;
    end else begin
      if (!r1 || !l1) m_lock = -1;
    end
    if (!r1 || e1) m_wait = 0;
    else if (m_wait < MaxWait) m_wait++;
    if (e0 || e1) m_last = e1 ? 1 : 0;
    @(negedge clk);
  endtask

  // Assert reset at a falling edge with requests possibly pending
  task automatic apply_reset();
    exp_q.delete();
    resetb = 1'b0;
    #1;
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_rvalid0", bus.rvalid0, 0);
    check("rst_rvalid1", bus.rvalid1, 0);
    check("rst_dm_addr", bus.dm_addr, 0);
    check("rst_dm_we", bus.dm_we, 0);
    check("rst_dm_be", bus.dm_be, 4'hF);
    check("rst_is_signed", bus.is_signed, 0);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    m_lock = -1; m_wait = 0; m_last = 0; e0 = 1'b0; e1 = 1'b0;
  endtask

  initial begin
    int n0;
    logic seen1;
    legal_be = '{BeWord, BeHalfHi, BeHalfLo, BeByte0, BeByte1, BeByte2, BeByte3};
    bases = '{ImBase, DmBase, IoBase};
    set0(1'b0, 1'b0, 1'b0, 32'h0);
    set1(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    apply_reset();

    // Single read by requester 0
    set0(1'b1, 1'b0, 1'b0, 32'h1000_0010);
    set1(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    check("single_gnt0", dut_g0, 1);
    set0(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();

    // Contention from a fresh reset
    apply_reset();
    set0(1'b1, 1'b0, 1'b0, 32'h1000_0100);
    set1(1'b1, 1'b0, 1'b1, 32'h1000_0200);
    n0 = 0; seen1 = 1'b0;
    for (int i = 0; i < 20 && !seen1; i++) begin
      cycle();
      if (dut_g1) seen1 = 1'b1;
      else if (dut_g0) n0++;
    end
    check("contention_gnt1_seen", seen1, 1);
    check("contention_gnt0_run", n0, RrEn ? 0 : MaxWait);
    repeat (4) cycle();

    // Locked burst by requester 1 while requester 0 waits
    apply_reset();
    set0(1'b0, 1'b0, 1'b0, 32'h0);
    set1(1'b1, 1'b1, 1'b1, 32'h1000_0300);
    cycle();
    set0(1'b1, 1'b0, 1'b0, 32'h1000_0400);
    set1(1'b1, 1'b1, 1'b1, 32'h1000_0304);
    cycle();
    check("lock1_blocks_gnt0", dut_g0, 0);
    set1(1'b1, 1'b0, 1'b1, 32'h1000_0308);
    cycle();
    check("lock1_last_gnt0", dut_g0, 0);
    set1(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    check("lock1_release_gnt0", dut_g0, 1);
    set0(1'b0, 1'b0, 1'b0, 32'h0);

    // Lock abandoned by requester 0
    set0(1'b1, 1'b1, 1'b0, 32'h1000_0500);
    cycle();
    set0(1'b0, 1'b0, 1'b0, 32'h0);
    set1(1'b1, 1'b0, 1'b0, 32'h1000_0600);
    cycle();
    check("abandon_no_gnt1", dut_g1, 0);
    cycle();
    check("abandon_then_gnt1", dut_g1, 1);
    set1(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();

    // Reset in the cycle after a grant drops the response
    set0(1'b1, 1'b0, 1'b0, 32'h1000_0700);
    cycle();
    apply_reset();
    set0(1'b0, 1'b0, 1'b0, 32'h0);

    // Randomised traffic
    repeat (2000) begin
      rand_inputs();
      cycle();
    end

    set0(1'b0, 1'b0, 1'b0, 32'h0);
    set1(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle();
    check("responses_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
